vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 106 ++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 Hz timing generator: pixel counters, sync pulses, frame strobe and colour blanking.
// Optional macro VGA_PIPE_ALIGN_EN delays hsync/vsync/blanking by one cycle to match a registered rgb_in.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk_d,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [11:0] rgb_out
);

  localparam logic [9:0] H_MAX = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       video_on_q, video_on_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    h_d = (h_q == H_MAX) ? '0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
    end
  end

  // Decoding the next-state counters keeps the registered flags coincident with pixel_x/pixel_y.
  always_comb begin
    video_on_d    = (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d       = !((h_d >= H_SS) && (h_d <= H_SE));
    vsync_d       = !((v_d >= V_SS) && (v_d <= V_SE));
    frame_start_d = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= H_MAX;
      v_q           <= V_MAX;
      video_on_q    <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

`ifdef VGA_PIPE_ALIGN_EN
  logic hsync_dly_q;
  logic vsync_dly_q;
  logic video_on_dly_q;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      hsync_dly_q    <= 1'b1;
      vsync_dly_q    <= 1'b1;
      video_on_dly_q <= 1'b0;
    end else begin
      hsync_dly_q    <= hsync_q;
      vsync_dly_q    <= vsync_q;
      video_on_dly_q <= video_on_q;
    end
  end

  assign hsync   = hsync_dly_q;
  assign vsync   = vsync_dly_q;
  assign rgb_out = video_on_dly_q ? rgb_in : '0;
`else
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign rgb_out = video_on_q ? rgb_in : '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-size instance for line timing and a short-frame
// instance (20 lines) so vertical/frame behaviour fits in a short run.
module tb_vga_timing_gen;

`ifdef VGA_PIPE_ALIGN_EN
  localparam int ALIGN = 1;
`else
  localparam int ALIGN = 0;
`endif

  logic        clk_d = 1'b0;
  logic        rst_n;
  logic [11:0] rgb_in;

  logic [9:0]  px, py;
  logic        von, hs, vs, fs;
  logic [11:0] rgbo;

  logic [9:0]  s_px, s_py;
  logic        s_von, s_hs, s_vs, s_fs;
  logic [11:0] s_rgbo;

  int tests_run = 0;
  int tests_failed = 0;

  always #10 clk_d = ~clk_d;

  vga_timing_gen dut (
    .clk_d(clk_d), .rst_n(rst_n), .rgb_in(rgb_in),
    .pixel_x(px), .pixel_y(py), .video_on(von), .hsync(hs), .vsync(vs),
    .frame_start(fs), .rgb_out(rgbo)
  );

  // Short frame: lines 0..11 active, vsync on lines 14..15, 20 lines total.
  vga_timing_gen #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) dut_s (
    .clk_d(clk_d), .rst_n(rst_n), .rgb_in(rgb_in),
    .pixel_x(s_px), .pixel_y(s_py), .video_on(s_von), .hsync(s_hs), .vsync(s_vs),
    .frame_start(s_fs), .rgb_out(s_rgbo)
  );

  task automatic test_reset();
    rst_n  = 1'b0;
    rgb_in = 12'hFFF;
    repeat (2) @(negedge clk_d);
    tests_run++;
    if ({px, py, von, hs, vs, fs, rgbo} !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}) begin
      tests_failed++;
      $display("FAIL reset_hold: got x=%0d y=%0d von=%b hs=%b vs=%b fs=%b rgb=%h expected 799/524/0/1/1/0/000",
               px, py, von, hs, vs, fs, rgbo);
    end
    tests_run++;
    if (s_py !== 10'd19) begin
      tests_failed++;
      $display("FAIL reset_small_y: got %0d expected 19", s_py);
    end

    rst_n = 1'b1;
    @(negedge clk_d);
    tests_run++;
    if ({px, py, von, fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL release_first_edge: got x=%0d y=%0d von=%b fs=%b expected 0/0/1/1", px, py, von, fs);
    end

    repeat (300) @(negedge clk_d);
    tests_run++;
    if ({px, py, fs} !== {10'd300, 10'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_line_pos: got x=%0d y=%0d fs=%b expected 300/0/0", px, py, fs);
    end

    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({px, py, von, hs, vs, fs, rgbo} !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000}) begin
      tests_failed++;
      $display("FAIL async_reset: got x=%0d y=%0d von=%b hs=%b vs=%b fs=%b rgb=%h expected 799/524/0/1/1/0/000",
               px, py, von, hs, vs, fs, rgbo);
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk_d);
    tests_run++;
    if ({px, py, von, fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL rerelease_first_edge: got x=%0d y=%0d von=%b fs=%b expected 0/0/1/1", px, py, von, fs);
    end
  endtask

  // Entered at (0,0); walks one full line and leaves at (0,1).
  task automatic test_line();
    int hs_low = 0, hs_first = -1, von_cnt = 0, von_last = -1, px_bad = 0;
    logic [11:0] rgb_at0 = 12'h0, rgb_at639 = 12'h0, rgb_at640 = 12'h0, rgb_at641 = 12'h0;
    for (int i = 0; i < 800; i++) begin
      if (px !== 10'(i) || py !== 10'd0) px_bad++;
      if (hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (von === 1'b1) begin
        von_cnt++;
        von_last = i;
      end
      if (i == 0)   rgb_at0   = rgbo;
      if (i == 639) rgb_at639 = rgbo;
      if (i == 640) rgb_at640 = rgbo;
      if (i == 641) rgb_at641 = rgbo;
      @(negedge clk_d);
    end
    tests_run++;
    if (px_bad != 0) begin
      tests_failed++;
      $display("FAIL px_sequence: got %0d bad samples expected 0", px_bad);
    end
    tests_run++;
    if (hs_low != 96 || hs_first != 656 + ALIGN) begin
      tests_failed++;
      $display("FAIL hsync_pulse: got %0d low from x=%0d expected 96 from x=%0d", hs_low, hs_first, 656 + ALIGN);
    end
    tests_run++;
    if (von_cnt != 640 || von_last != 639) begin
      tests_failed++;
      $display("FAIL video_on_span: got %0d ending x=%0d expected 640 ending x=639", von_cnt, von_last);
    end
    tests_run++;
    if (rgb_at0 !== (ALIGN != 0 ? 12'h000 : 12'hFFF) || rgb_at639 !== 12'hFFF) begin
      tests_failed++;
      $display("FAIL rgb_line_start: got x0=%h x639=%h expected x0=%h x639=fff",
               rgb_at0, rgb_at639, (ALIGN != 0 ? 12'h000 : 12'hFFF));
    end
    tests_run++;
    if (rgb_at640 !== (ALIGN != 0 ? 12'hFFF : 12'h000) || rgb_at641 !== 12'h000) begin
      tests_failed++;
      $display("FAIL rgb_line_end: got x640=%h x641=%h expected x640=%h x641=000",
               rgb_at640, rgb_at641, (ALIGN != 0 ? 12'hFFF : 12'h000));
    end
    tests_run++;
    if ({px, py} !== {10'd0, 10'd1}) begin
      tests_failed++;
      $display("FAIL line_wrap: got x=%0d y=%0d expected 0/1", px, py);
    end
  endtask

  // Entered at (0,1).
  task automatic test_wrap_line();
    repeat (9 * 800 + 799) @(negedge clk_d);
    tests_run++;
    if ({px, py} !== {10'd799, 10'd10}) begin
      tests_failed++;
      $display("FAIL pre_wrap_pos: got x=%0d y=%0d expected 799/10", px, py);
    end
    @(negedge clk_d);
    tests_run++;
    if ({px, py, fs} !== {10'd0, 10'd11, 1'b0}) begin
      tests_failed++;
      $display("FAIL wrap_to_next_line: got x=%0d y=%0d fs=%b expected 0/11/0", px, py, fs);
    end
  endtask

  // Short-frame instance: frame = 20 * 800 = 16000 cycles.
  task automatic test_frame();
    int waited = 0, vs_low = 0, vs_fx = -1, vs_fy = -1, fs_cnt = 0;
    logic [9:0] end_x = '0, end_y = '0;
    logic [11:0] rgb_y11 = 12'h0, rgb_y12 = 12'h0;
    while (s_fs !== 1'b1 && waited < 20000) begin
      @(negedge clk_d);
      waited++;
    end
    tests_run++;
    if (s_fs !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_start_seen: got none within %0d cycles expected a pulse", waited);
    end
    for (int k = 0; k < 16000; k++) begin
      if (s_vs === 1'b0) begin
        if (vs_fx < 0) begin
          vs_fx = int'(s_px);
          vs_fy = int'(s_py);
        end
        vs_low++;
      end
      if (s_fs === 1'b1) fs_cnt++;
      if (k == 11 * 800 + 5) rgb_y11 = s_rgbo;
      if (k == 12 * 800 + 5) rgb_y12 = s_rgbo;
      if (k == 15999) begin
        end_x = s_px;
        end_y = s_py;
      end
      @(negedge clk_d);
    end
    tests_run++;
    if (vs_low != 1600 || vs_fx != ALIGN || vs_fy != 14) begin
      tests_failed++;
      $display("FAIL vsync_pulse: got %0d low from (%0d,%0d) expected 1600 from (%0d,14)",
               vs_low, vs_fx, vs_fy, ALIGN);
    end
    tests_run++;
    if (fs_cnt != 1) begin
      tests_failed++;
      $display("FAIL frame_start_count: got %0d pulses in one frame expected 1", fs_cnt);
    end
    tests_run++;
    if ({end_x, end_y} !== {10'd799, 10'd19}) begin
      tests_failed++;
      $display("FAIL frame_last_pos: got x=%0d y=%0d expected 799/19", end_x, end_y);
    end
    tests_run++;
    if ({s_px, s_py, s_fs} !== {10'd0, 10'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL frame_wrap_period: got x=%0d y=%0d fs=%b expected 0/0/1", s_px, s_py, s_fs);
    end
    tests_run++;
    if (rgb_y11 !== 12'hFFF || rgb_y12 !== 12'h000) begin
      tests_failed++;
      $display("FAIL rgb_vertical_blank: got y11=%h y12=%h expected fff/000", rgb_y11, rgb_y12);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_wrap_line();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
